// File: rtl/mac_dot_sequencer.sv
// Operand sequencer for the TinyML MAC: streams A/B word pairs from memory into
// the MAC (first pair multiply, rest accumulate) and latches the final dot product.
module mac_dot_sequencer #(
  parameter int AW      = 16,
  parameter int LEN_W   = 16,
  parameter int MAC_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [AW-1:0]    base_a,
  input  logic [AW-1:0]    base_b,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result,
  output logic             mem_req,
  output logic [AW-1:0]    mem_addr,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [31:0]      mac_a,
  output logic [31:0]      mac_b,
  output logic             mac_en,
  output logic             mac_mode,
  input  logic [31:0]      mac_o
);

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_ISSUE, S_DRAIN, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      ptr_a_q, ptr_a_d;
  logic [AW-1:0]      ptr_b_q, ptr_b_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               first_q, first_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [31:0]        result_q, result_d;
  logic [31:0]        mac_a_q, mac_a_d;
  logic [31:0]        mac_b_q, mac_b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mem_req_q, mem_req_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic               mac_en_q, mac_en_d;
  logic               mac_mode_q, mac_mode_d;

  always_comb begin
    state_d  = state_q;
    ptr_a_d  = ptr_a_q;
    ptr_b_d  = ptr_b_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    drain_d  = drain_q;
    result_d = result_q;
    mac_a_d  = mac_a_q;
    mac_b_d  = mac_b_q;

    // Abort takes priority so a late ack or drain cannot disturb the held result.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            result_d = '0;
            if (length != '0) begin
              ptr_a_d = base_a;
              ptr_b_d = base_b;
              cnt_d   = length;
              first_d = 1'b1;
              state_d = S_RD_A;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_RD_A: begin
          if (mem_ack) begin
            mac_a_d = mem_rdata;
            state_d = S_RD_B;
          end
        end
        S_RD_B: begin
          if (mem_ack) begin
            mac_b_d = mem_rdata;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          first_d = 1'b0;
          ptr_a_d = ptr_a_q + AW'(1);
          ptr_b_d = ptr_b_q + AW'(1);
          cnt_d   = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            drain_d = DW'(MAC_LAT - 1);
            state_d = S_DRAIN;
          end else begin
            state_d = S_RD_A;
          end
        end
        S_DRAIN: begin
          if (drain_q == '0) begin
            result_d = mac_o;
            state_d  = S_DONE;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they come straight off flops.
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    mem_req_d  = (state_d == S_RD_A) || (state_d == S_RD_B);
    mac_en_d   = (state_d == S_ISSUE);
    mac_mode_d = (state_d == S_ISSUE) && !first_d;
    mem_addr_d = mem_addr_q;
    if (state_d == S_RD_A)      mem_addr_d = ptr_a_d;
    else if (state_d == S_RD_B) mem_addr_d = ptr_b_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_a_q    <= '0;
      ptr_b_q    <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      drain_q    <= '0;
      result_q   <= '0;
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mac_en_q   <= 1'b0;
      mac_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_a_q    <= ptr_a_d;
      ptr_b_q    <= ptr_b_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      drain_q    <= drain_d;
      result_q   <= result_d;
      mac_a_q    <= mac_a_d;
      mac_b_q    <= mac_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mac_en_q   <= mac_en_d;
      mac_mode_q <= mac_mode_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign mac_a    = mac_a_q;
  assign mac_b    = mac_b_q;
  assign mac_en   = mac_en_q;
  assign mac_mode = mac_mode_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer: memory with programmable ack delay and a
// one-cycle MAC model, a vector table plus abort/reset/back-to-back sequences.
module tb_mac_dot_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] base_a;
  logic [15:0] base_b;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] mac_a;
  logic [31:0] mac_b;
  logic        mac_en;
  logic        mac_mode;
  logic [31:0] mac_o;

  mac_dot_sequencer #(.AW(16), .LEN_W(16), .MAC_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_a(base_a), .base_b(base_b), .length(length),
    .busy(busy), .done(done), .result(result),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .mac_mode(mac_mode), .mac_o(mac_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with ack after ack_delay wait cycles
  bit [31:0] mem [0:65535];
  int        ack_delay;
  int        wait_cnt;
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  always @(posedge clk) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;

  // MAC model, result visible one cycle after mac_en
  bit [31:0] mac_acc;
  assign mac_o = mac_acc;
  always @(posedge clk) if (mac_en) mac_acc <= mac_mode ? mac_acc + mac_a * mac_b : mac_a * mac_b;

  int n_vec, n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  bit          modes[$];
  logic [15:0] addrs[$];
  int          req_cnt, done_cnt;
  logic        prev_req, prev_ack;
  logic [15:0] prev_addr;

  always @(negedge clk) begin
    if (mac_en) modes.push_back(mac_mode);
    if (mem_req) req_cnt++;
    if (mem_req && mem_ack) addrs.push_back(mem_addr);
    if (done) done_cnt++;
    if (mem_req && prev_req && !prev_ack) chk("addr_stable", mem_addr, prev_addr);
    prev_req  = mem_req;
    prev_ack  = mem_ack;
    prev_addr = mem_addr;
  end

  // Starts an op at the current negedge (cycle 0); returns in the cycle after DONE.
  // poke >= 0 re-pulses start with other operands at that cycle while busy.
  task automatic run_op(input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] len,
                        input int dly, input int poke, output int done_cyc, output logic [31:0] res);
    int cyc;
    ack_delay = dly;
    modes.delete();
    addrs.delete();
    req_cnt  = 0;
    base_a   = ba;
    base_b   = bb;
    length   = len;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 300) begin
      if (cyc == poke) begin
        start = 1'b1; length = 16'd1; base_a = 16'h0030; base_b = 16'h0031;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    done_cyc = cyc;
    res      = result;
    @(negedge clk);
    chk("busy_drop", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] ba;
    logic [15:0] bb;
    logic [15:0] len;
    int          dly;
    logic [31:0] exp_res;
    int          exp_done;
  } vec_t;

  vec_t vt[5];

  initial begin
    int          dc;
    logic [31:0] r;
    n_vec = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    base_a = '0; base_b = '0; length = '0; ack_delay = 0;

    mem[16'h0010] = 32'hFFFFFFF6; mem[16'h0011] = 32'h00000001;
    mem[16'h0020] = 32'h00000001; mem[16'h0021] = 32'h00000008;
    mem[16'h0030] = 32'd7;        mem[16'h0031] = 32'd6;
    mem[16'h0040] = 32'd2; mem[16'h0041] = 32'd3; mem[16'h0042] = 32'd4;
    mem[16'h0050] = 32'd5; mem[16'h0051] = 32'd6; mem[16'h0052] = 32'd7;
    mem[16'h0060] = 32'hFFFFFFFF; mem[16'h0061] = 32'hFFFFFFFF;
    mem[16'h0070] = 32'hFFFFFFFF; mem[16'h0071] = 32'hFFFFFFFF;
    mem[16'h00A0] = 32'd3; mem[16'h00B0] = 32'd5;
    mem[16'hFFFF] = 32'd3; mem[16'h0000] = 32'd4;
    mem[16'h0100] = 32'd5; mem[16'h0101] = 32'd6;

    vt[0] = '{16'h0010, 16'h0020, 16'd2, 0, 32'hFFFFFFFE, 8};
    vt[1] = '{16'h0030, 16'h0031, 16'd1, 3, 32'd42,       11};
    vt[2] = '{16'h0200, 16'h0300, 16'd0, 0, 32'd0,        1};
    vt[3] = '{16'h0040, 16'h0050, 16'd3, 1, 32'd56,       17};
    vt[4] = '{16'h0060, 16'h0070, 16'd2, 0, 32'd2,        8};

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mac_en", {31'd0, mac_en}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_op(vt[i].ba, vt[i].bb, vt[i].len, vt[i].dly, -1, dc, r);
      chk($sformatf("v%0d_result", i), r, vt[i].exp_res);
      chk($sformatf("v%0d_done_cyc", i), dc, vt[i].exp_done);
      chk($sformatf("v%0d_n_mac", i), modes.size(), {16'd0, vt[i].len});
      chk($sformatf("v%0d_n_read", i), addrs.size(), 2 * vt[i].len);
      if (vt[i].len == 16'd0) chk("v_len0_no_req", req_cnt, 32'd0);
      if (modes.size() > 0) begin
        chk($sformatf("v%0d_mode_first", i), {31'd0, modes[0]}, 32'd0);
        chk($sformatf("v%0d_mode_last", i), {31'd0, modes[modes.size()-1]}, {31'd0, vt[i].len > 1});
      end
    end

    // Abort in the second RD_B of an N=4 run
    done_cnt = 0;
    ack_delay = 0;
    base_a = 16'h0080; base_b = 16'h0090; length = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_rdb_addr", {16'd0, mem_addr}, 32'h0091);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
    chk("abort_result", result, 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_cnt, 32'd0);

    // Abort and start together in IDLE: nothing accepted
    start = 1'b1; abort = 1'b1; length = 16'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("abort_start_busy2", {31'd0, busy}, 32'd0);

    run_op(16'h00A0, 16'h00B0, 16'd1, 0, -1, dc, r);
    chk("post_abort_result", r, 32'd15);
    chk("post_abort_done_cyc", dc, 32'd5);

    // Start while busy is ignored; next op starts in the cycle after DONE
    run_op(16'h0010, 16'h0020, 16'd2, 0, 4, dc, r);
    chk("busy_start_result", r, 32'hFFFFFFFE);
    chk("busy_start_done_cyc", dc, 32'd8);
    chk("busy_start_n_mac", modes.size(), 32'd2);
    run_op(16'hFFFF, 16'h0100, 16'd2, 0, -1, dc, r);
    chk("wrap_result", r, 32'd39);
    chk("wrap_done_cyc", dc, 32'd8);
    if (addrs.size() == 4) begin
      chk("wrap_addr_a0", {16'd0, addrs[0]}, 32'h0000FFFF);
      chk("wrap_addr_a1", {16'd0, addrs[2]}, 32'h00000000);
    end else begin
      chk("wrap_n_read", addrs.size(), 32'd4);
    end

    // Reset asserted during ISSUE
    base_a = 16'h0010; base_b = 16'h0020; length = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("issue_mac_en", {31'd0, mac_en}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("mrst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("mrst_mac_en", {31'd0, mac_en}, 32'd0);
    chk("mrst_mac_mode", {31'd0, mac_mode}, 32'd0);
    chk("mrst_result", result, 32'd0);
    chk("mrst_mac_a", mac_a, 32'd0);
    chk("mrst_mac_b", mac_b, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_dot_sequencer.md
# mac_dot_sequencer

Operand sequencer that drives the DLX TinyML MAC unit from the initiator side. On a start command it fetches pairs of 32-bit words from two vectors in data memory through a request/acknowledge read port, then issues each pair to the MAC unit. The first pair is sent in multiply mode and every later pair in accumulate mode. After the last MAC result settles it latches it and reports completion to the core. The block sits between the DLX execute stage (command/status) and the MAC_Unit (operand/result).

## Interface
- AW, 16: word-address width of the memory read port.
- LEN_W, 16: vector-length width.
- MAC_LAT, 1: cycles from a `mac_en` cycle until `mac_o` reflects it (≥1).
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe, sampled only in IDLE.
- abort  in  1  cancel current operation.
- base_a  in  AW  word address of vector A element 0.
- base_b  in  AW  word address of vector B element 0.
- length  in  LEN_W  number of element pairs N.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- result  out  32  latched dot product, held until next accepted start.
- mem_req  out  1  read request.
- mem_addr  out  AW  read word address.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  read acknowledge.
- mac_a  out  32  MAC operand a.
- mac_b  out  32  MAC operand b.
- mac_en  out  1  MAC issue strobe.
- mac_mode  out  1  MAC mul_mac_signal: 0 = multiply (accumulator overwritten), 1 = accumulate.
- mac_o  in  32  MAC output.

## Operation
- States: IDLE, RD_A, RD_B, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 and length≠0: latch ptr_a=base_a, ptr_b=base_b, cnt=length, first=1; clear result → RD_A.
  - start=1 and length=0: result=0 → DONE. No memory or MAC activity.
- RD_A: mem_req=1, mem_addr=ptr_a. On mem_ack, latch mem_rdata into mac_a → RD_B.
- RD_B: mem_req=1, mem_addr=ptr_b. On mem_ack, latch mem_rdata into mac_b → ISSUE.
- ISSUE: mac_en=1 for exactly one cycle, mac_mode=~first. Then first=0, ptr_a+1, ptr_b+1, cnt-1. If cnt was 1 → DRAIN, else → RD_A.
- DRAIN: wait MAC_LAT cycles. On the last DRAIN cycle, result<=mac_o → DONE.
- DONE: done=1 for one cycle → IDLE.
- mem_req and mem_addr stay stable until mem_ack. mem_ack outside RD_A/RD_B is ignored.
- mac_a and mac_b hold their last values when mac_en=0.
- mac_mode is 0 outside ISSUE.
- Arithmetic and overflow wrap belong to the MAC. The sequencer passes 32-bit values through untouched.
- Pointers wrap modulo 2^AW.
- start while busy is ignored.
- abort (any non-IDLE state) → IDLE next cycle:
  - mem_req and mac_en drop; no done pulse.
  - result keeps its value (cleared at accept if the aborted op had started).
- abort and start in the same IDLE cycle: abort wins, no operation is accepted.
- rst overrides everything.

## Timing
- Reset values:
  - State IDLE.
  - busy, done, mem_req, mac_en, mac_mode = 0.
  - result, mac_a, mac_b, mem_addr = 0.
  - Internal counters and pointers = 0.
- Start is accepted in cycle 0; busy=1 from cycle 1.
- With zero-wait memory (mem_ack in the same cycle as mem_req), each element takes 3 cycles (RD_A, RD_B, ISSUE).
- With zero-wait memory, done is high in cycle 3N+MAC_LAT+1 and busy drops in the following cycle.
- Each memory wait cycle extends the total by one.
- result becomes valid in the DONE cycle.
- Rest-to-rest, back-to-back operations are possible: start can be accepted in the cycle after DONE.
- All outputs are registered or decoded from the registered state. There is no combinational path from mem_ack or mac_o to any output.

## Test plan
- N=2, A=[0xFFFFFFF6, 0x00000001], B=[0x00000001, 0x00000008], zero-wait memory, MAC_LAT=1 →
  - two mac_en pulses, modes 0 then 1;
  - done in cycle 8;
  - result=0xFFFFFFFE (-2).
- N=1, A=[7], B=[6], mem_ack delayed 3 cycles on every read →
  - mem_addr stable while waiting;
  - done in cycle 11;
  - result=42.
- length=0 with start →
  - no mem_req, no mac_en;
  - done in cycle 1;
  - result=0.
- N=4 run, abort asserted in the second RD_B →
  - next cycle: IDLE, busy=0, mem_req=0;
  - no done pulse.
  - A new start then runs N=1 (3×5) to result=15.
- start pulsed again while busy → ignored, first result unchanged. Then:
  - start in the cycle after DONE is accepted;
  - base_a=0xFFFF with N=2 → second read of A at address 0x0000.
- rst asserted mid-ISSUE → next cycle every output equals its reset value.
